// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Per-register countdown scoreboard for the ID stage of a 5-stage RV32
//   pipeline. Each architectural register carries a counter loaded when a
//   producer issues. A consumer may proceed once that counter has drained far
//   enough: EX-stage consumers need cnt <= BR_EXTRA, and ID-stage branch
//   compares need cnt == 0. A taken redirect flushes IF/ID for BR_PENALTY
//   cycles.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   id_valid_i                     valid instruction in ID
//   id_rs1_i/id_rs2_i              source register indices
//   id_rs1_used_i/id_rs2_used_i    source is actually read
//   id_rd_i, id_regwrite_i         destination and its write enable
//   id_lat_i                       extra cycles a dependent EX consumer waits
//   id_is_branch_i                 operands are compared in ID
//   redirect_i                     taken control transfer resolved in ID
//   pc_write_o, if_id_write_o      PC / IF-ID write enables
//   if_id_flush_o                  turn IF/ID into a bubble
//   id_ex_ctrl_flush_o             zero ID/EX control (bubble into EX)
//   stall_count_o, flush_count_o   saturating performance counters
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | normal operation, hazard checks active
// S_FLUSH | trailing redirect penalty cycles, ID contents ignored

module hazard_scoreboard_unit #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int CW         = 4,
  parameter int MAX_LAT    = 7,
  parameter int BR_EXTRA   = 2,
  parameter int BR_PENALTY = 1,
  parameter int PCW        = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           id_valid_i,
  input  logic [AW-1:0]  id_rs1_i,
  input  logic [AW-1:0]  id_rs2_i,
  input  logic           id_rs1_used_i,
  input  logic           id_rs2_used_i,
  input  logic [AW-1:0]  id_rd_i,
  input  logic           id_regwrite_i,
  input  logic [CW-1:0]  id_lat_i,
  input  logic           id_is_branch_i,
  input  logic           redirect_i,
  output logic           pc_write_o,
  output logic           if_id_write_o,
  output logic           if_id_flush_o,
  output logic           id_ex_ctrl_flush_o,
  output logic [PCW-1:0] stall_count_o,
  output logic [PCW-1:0] flush_count_o
);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  // BR_PENALTY is at most 4, so the flush counter never needs more than 2 bits.
  localparam int FLW = 2;
  localparam logic [CW-1:0]  BR_EXTRA_C = CW'(BR_EXTRA);
  localparam logic [CW-1:0]  MAX_LAT_C  = CW'(MAX_LAT);
  localparam logic [FLW-1:0] FL_INIT    = FLW'((BR_PENALTY > 1) ? BR_PENALTY - 2 : 0);

  state_e         state_q, state_d;
  logic [FLW-1:0] fl_q, fl_d;
  logic [CW-1:0]  cnt_q [NREG];
  logic [CW-1:0]  cnt_d [NREG];
  logic [PCW-1:0] stall_cnt_q, stall_cnt_d;
  logic [PCW-1:0] flush_cnt_q, flush_cnt_d;

  logic [CW-1:0]  lat_clamped;
  logic [CW-1:0]  issue_val;
  logic           rs1_blocked, rs2_blocked, waw_blocked;
  logic           stall, issue;
  logic           pc_write, if_id_write, if_id_flush, id_ex_flush;

  // Hazard evaluation always reads the pre-update counters, so an instruction
  // with rd == rs1 is checked against the older producer.
  always_comb begin
    lat_clamped = (id_lat_i > MAX_LAT_C) ? MAX_LAT_C : id_lat_i;
    issue_val   = lat_clamped + BR_EXTRA_C;
    rs1_blocked = id_rs1_used_i &
                  (id_is_branch_i ? (cnt_q[id_rs1_i] != '0) : (cnt_q[id_rs1_i] > BR_EXTRA_C));
    rs2_blocked = id_rs2_used_i &
                  (id_is_branch_i ? (cnt_q[id_rs2_i] != '0) : (cnt_q[id_rs2_i] > BR_EXTRA_C));
    // An older slow write must land no later than the younger one.
    waw_blocked = id_regwrite_i & (id_rd_i != '0) & (cnt_q[id_rd_i] > issue_val);
    stall       = ~rst_i & id_valid_i & (state_q == S_RUN) &
                  (rs1_blocked | rs2_blocked | waw_blocked);
    issue       = ~rst_i & id_valid_i & (state_q == S_RUN) & ~stall;
  end

  always_comb begin
    state_d     = state_q;
    fl_d        = fl_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        S_RUN: begin
          if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (redirect_i) begin
            if_id_flush = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = S_FLUSH;
              fl_d    = FL_INIT;
            end
          end
        end
        S_FLUSH: begin
          if_id_flush = 1'b1;
          if (fl_q == '0) state_d = S_RUN;
          else            fl_d    = fl_q - FLW'(1);
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // x0 never holds a pending write; an issuing write overrides the decrement.
  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue && id_regwrite_i && (id_rd_i == AW'(r)))
        cnt_d[r] = issue_val;
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CW'(1);
      else
        cnt_d[r] = cnt_q[r];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + PCW'(1);
    if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PCW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      fl_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      fl_q        <= fl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc_write_o         = pc_write;
  assign if_id_write_o      = if_id_write;
  assign if_id_flush_o      = if_id_flush;
  assign id_ex_ctrl_flush_o = id_ex_flush;
  assign stall_count_o      = stall_cnt_q;
  assign flush_count_o      = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit. Two instances share one stimulus:
// u_a uses BR_PENALTY=1/PCW=16, u_b uses BR_PENALTY=3/PCW=4. Both are compared
// every cycle against a pending-cycles model; u_a is also checked against a
// fixed vector table, and hand sequences cover flush, reset and saturation.

module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, u1, u2, rw, br, redir;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] lat;

  logic        pc_a, ifw_a, iff_a, idf_a;
  logic [15:0] sc_a, fc_a;
  logic        pc_b, ifw_b, iff_b, idf_b;
  logic [3:0]  sc_b, fc_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.BR_PENALTY(1), .PCW(16)) u_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_lat_i(lat), .id_is_branch_i(br), .redirect_i(redir),
    .pc_write_o(pc_a), .if_id_write_o(ifw_a), .if_id_flush_o(iff_a),
    .id_ex_ctrl_flush_o(idf_a), .stall_count_o(sc_a), .flush_count_o(fc_a));

  hazard_scoreboard_unit #(.BR_PENALTY(3), .PCW(4)) u_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_i(rd), .id_regwrite_i(rw),
    .id_lat_i(lat), .id_is_branch_i(br), .redirect_i(redir),
    .pc_write_o(pc_b), .if_id_write_o(ifw_b), .if_id_flush_o(iff_b),
    .id_ex_ctrl_flush_o(idf_b), .stall_count_o(sc_b), .flush_count_o(fc_b));

  // ---------------- reference model ----------------
  // pend[k][r]: cycles until register r stops blocking anyone.
  // frem[k]   : trailing flush cycles still owed after a redirect.
  int pend [2][32];
  int frem [2];
  int msc  [2];
  int mfc  [2];
  int bpen [2] = '{1, 3};
  int cmax [2] = '{65535, 15};

  function automatic int eff_lat();
    return (int'(lat) > 7) ? 7 : int'(lat);
  endfunction

  function automatic bit blocked(int k, logic [4:0] r);
    if (br) return pend[k][r] > 0;
    return pend[k][r] > 2;
  endfunction

  // {stall, pc_write, if_id_write, if_id_flush, id_ex_ctrl_flush}
  function automatic logic [4:0] mexp(int k);
    bit st;
    if (rst) return 5'b0_1100;
    if (frem[k] > 0) return 5'b0_1110;
    st = valid && ((u1 && blocked(k, rs1)) || (u2 && blocked(k, rs2)) ||
                   (rw && rd != 0 && pend[k][rd] > eff_lat() + 2));
    if (st) return 5'b1_0001;
    if (redir) return 5'b0_1110;
    return 5'b0_1100;
  endfunction

  task automatic mclear(int k);
    for (int r = 0; r < 32; r++) pend[k][r] = 0;
    frem[k] = 0; msc[k] = 0; mfc[k] = 0;
  endtask

  task automatic mstep(int k);
    logic [4:0] e;
    bit st, iss, busy;
    if (rst) begin mclear(k); return; end
    e    = mexp(k);
    st   = e[4];
    busy = frem[k] > 0;
    iss  = valid && !busy && !st;
    if (st   && msc[k] < cmax[k]) msc[k]++;
    if (e[1] && mfc[k] < cmax[k]) mfc[k]++;
    if (busy) frem[k]--;
    else if (!st && redir && bpen[k] > 1) frem[k] = bpen[k] - 1;
    for (int r = 1; r < 32; r++) begin
      if (iss && rw && rd == r) pend[k][r] = eff_lat() + 2;
      else if (pend[k][r] > 0)  pend[k][r]--;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int outs(int k);
    return (k == 0) ? int'({pc_a, ifw_a, iff_a, idf_a}) : int'({pc_b, ifw_b, iff_b, idf_b});
  endfunction

  // Called at a negedge: compare both instances to the model, advance it,
  // then move just past the next rising edge.
  task automatic check_step();
    logic [4:0] e;
    for (int k = 0; k < 2; k++) begin
      e = mexp(k);
      chk($sformatf("model_outs_%0d", k), outs(k), int'(e[3:0]));
      chk($sformatf("model_stall_count_%0d", k), (k == 0) ? int'(sc_a) : int'(sc_b), msc[k]);
      chk($sformatf("model_flush_count_%0d", k), (k == 0) ? int'(fc_a) : int'(fc_b), mfc[k]);
    end
    for (int k = 0; k < 2; k++) mstep(k);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_step();
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic us1,
                       input logic [4:0] s2, input logic us2, input logic [4:0] d,
                       input logic w, input logic [3:0] l, input logic b, input logic rr);
    valid = v; rs1 = s1; u1 = us1; rs2 = s2; u2 = us2;
    rd = d; rw = w; lat = l; br = b; redir = rr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [3:0] lat;
    logic       br;
    logic       redir;
    logic [3:0] exp_o;
    int         exp_sc;
    int         exp_fc;
  } vec_t;

  localparam logic [3:0] OK = 4'b1100;
  localparam logic [3:0] ST = 4'b0001;
  localparam logic [3:0] RD = 4'b1110;

  function automatic vec_t mk(logic v, logic [4:0] s1, logic us1, logic [4:0] s2, logic us2,
                              logic [4:0] d, logic w, logic [3:0] l, logic b, logic rr,
                              logic [3:0] eo, int esc, int efc);
    vec_t t;
    t.v = v; t.rs1 = s1; t.u1 = us1; t.rs2 = s2; t.u2 = us2; t.rd = d; t.rw = w;
    t.lat = l; t.br = b; t.redir = rr; t.exp_o = eo; t.exp_sc = esc; t.exp_fc = efc;
    return t;
  endfunction

  vec_t tbl [28];

  initial begin
    // load-use: x5 with lat 1, ALU consumer stalls exactly once
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, OK, 0, 0);
    tbl[1]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, ST, 0, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, OK, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK, 1, 0);
    // branch after ALU on x7: two stalls, then taken redirect
    tbl[5]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, OK, 1, 0);
    tbl[6]  = mk(1, 7, 1, 0, 1, 0, 0, 0, 1, 1, ST, 1, 0);
    tbl[7]  = mk(1, 7, 1, 0, 1, 0, 0, 0, 1, 1, ST, 2, 0);
    tbl[8]  = mk(1, 7, 1, 0, 1, 0, 0, 0, 1, 1, RD, 3, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK, 3, 1);
    // x0 write then read; unused rs2 ignored; used rs1 does stall
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 1, 7, 0, 0, OK, 3, 1);
    tbl[11] = mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, OK, 3, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 9, 1, 2, 0, 0, OK, 3, 1);
    tbl[13] = mk(1, 0, 1, 9, 0, 0, 0, 0, 0, 0, OK, 3, 1);
    tbl[14] = mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, ST, 3, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK, 4, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OK, 4, 1);
    // WAW: MUL to x3 then ALU to x3 waits 3 cycles; x3 ends at 2
    tbl[17] = mk(1, 0, 0, 0, 0, 3, 1, 3, 0, 0, OK, 4, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, ST, 4, 1);
    tbl[19] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, ST, 5, 1);
    tbl[20] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, ST, 6, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, OK, 7, 1);
    tbl[22] = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, ST, 7, 1);
    tbl[23] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, OK, 8, 1);
    // latency clamp: lat 12 acts as 7, so x10 holds 9
    tbl[24] = mk(1, 0, 0, 0, 0, 10, 1, 12, 0, 0, OK, 8, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 10, 1, 7, 0, 0, OK, 8, 1);
    tbl[26] = mk(1, 0, 0, 0, 0, 10, 1, 6, 0, 0, ST, 8, 1);
    tbl[27] = mk(1, 0, 0, 0, 0, 10, 1, 6, 0, 0, OK, 9, 1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();
    for (int k = 0; k < 2; k++) mclear(k);
    @(posedge clk);
    #1;
    // reset state while rst is still asserted
    @(negedge clk);
    chk("reset_outs_a", outs(0), int'(OK));
    chk("reset_outs_b", outs(1), int'(OK));
    chk("reset_sc_a", int'(sc_a), 0);
    chk("reset_fc_b", int'(fc_b), 0);
    check_step();
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].lat, tbl[i].br, tbl[i].redir);
      @(negedge clk);
      chk($sformatf("tbl%0d_outs", i), outs(0), int'(tbl[i].exp_o));
      chk($sformatf("tbl%0d_stall_count", i), int'(sc_a), tbl[i].exp_sc);
      chk($sformatf("tbl%0d_flush_count", i), int'(fc_a), tbl[i].exp_fc);
      check_step();
    end

    // multi-cycle flush on u_b: ID contents ignored in cycles 2-3
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_b_c1", outs(1), int'(RD));
    check_step();
    drive(1, 11, 1, 0, 0, 11, 1, 7, 0, 1);
    @(negedge clk);
    chk("flush_b_c2", outs(1), int'(RD));
    check_step();
    @(negedge clk);
    chk("flush_b_c3", outs(1), int'(RD));
    check_step();
    drive(1, 11, 1, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("flush_b_done", outs(1), int'(OK));
    chk("flush_b_count", int'(fc_b), 3);
    chk("flush_a_x11_stall", outs(0), int'(ST));
    check_step();

    // reset mid-stall
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    cyc();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_stall_pre", outs(0), int'(ST));
    check_step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall_during", outs(0), int'(OK));
    check_step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_after", outs(0), int'(OK));
    chk("rst_stall_count", int'(sc_a), 0);
    check_step();

    // reset mid-flush on u_b
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flush_after", outs(1), int'(OK));
    check_step();

    // stall_count saturation on the 4-bit instance
    do_reset();
    for (int g = 0; g < 3; g++) begin
      drive(1, 0, 0, 0, 0, 12, 1, 7, 0, 0);
      cyc();
      drive(1, 12, 1, 0, 0, 0, 0, 0, 1, 0);
      for (int j = 0; j < 11; j++) cyc();
    end
    @(negedge clk);
    chk("sat_sc_b", int'(sc_b), 15);
    chk("sat_sc_a", int'(sc_a), 27);
    check_step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 63) == 0);
      valid = ($urandom_range(0, 3) != 0);
      rs1   = 5'($urandom_range(0, 15));
      rs2   = 5'($urandom_range(0, 15));
      u1    = $urandom_range(0, 1) != 0;
      u2    = $urandom_range(0, 1) != 0;
      rd    = 5'($urandom_range(0, 15));
      rw    = $urandom_range(0, 1) != 0;
      lat   = 4'($urandom_range(0, 9));
      br    = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised next-generation hazard detection unit for the 5-stage RV32 pipeline. It replaces fixed-stage Rd comparisons with a per-register countdown scoreboard. This supports variable-latency producers (ALU, load, multi-cycle MUL/DIV), ID-stage branch compares, write-after-write ordering and a configurable multi-cycle redirect flush. It sits beside the ID stage and drives PC, IF/ID and ID/EX control.

Parameters:
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register index width
CW, 4, scoreboard counter width; must satisfy MAX_LAT+BR_EXTRA < 2^CW
MAX_LAT, 7, largest legal id_lat value
BR_EXTRA, 2, extra cycles a branch compared in ID waits beyond an EX-stage consumer
BR_PENALTY, 1, cycles IF/ID is flushed after a taken redirect (1..4)
PCW, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  valid instruction in ID
id_rs1, id_rs2  in  AW  source registers of ID instruction
id_rs1_used, id_rs2_used  in  1  source actually read
id_rd  in  AW  destination register
id_regwrite  in  1  ID instruction writes id_rd
id_lat  in  CW  stall cycles a dependent EX consumer needs (ALU 0, load 1, MUL 3, ...)
id_is_branch  in  1  ID instruction compares operands in ID (beq..bgeu, jalr)
redirect  in  1  taken branch/jal/jalr resolved in ID this cycle
pc_write  out  1  PC write enable
if_id_write  out  1  IF/ID write enable (0 = hold)
if_id_flush  out  1  clear IF/ID to bubble
id_ex_ctrl_flush  out  1  zero ID/EX control (insert bubble)
stall_count  out  PCW  saturating count of stall cycles
flush_count  out  PCW  saturating count of flush cycles

Behaviour:
- State: cnt[r] of CW bits per register, r=1..NREG-1; cnt[0] is constant 0. FSM {RUN, FLUSH} with a flush down-counter fl.
- Ready rules (combinational on current cnt):
  - non-branch source ready iff cnt[r] <= BR_EXTRA;
  - branch source ready iff cnt[r] == 0;
  - unused sources are ignored.
- WAW rule: if id_regwrite and id_rd != 0, require cnt[id_rd] <= id_lat+BR_EXTRA, so an older slow write cannot land after a younger one.
- stall = id_valid & state==RUN & (any used source not ready | WAW violation).
- Outputs, combinational:
  - stall: pc_write=0, if_id_write=0, id_ex_ctrl_flush=1, if_id_flush=0.
  - redirect & !stall & state==RUN: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_ctrl_flush=0.
  - state==FLUSH: if_id_flush=1, pc_write=1, if_id_write=1; id_valid and redirect are ignored.
  - otherwise: pc_write=1, if_id_write=1, flushes 0.
- Stall has priority over redirect; redirect is ignored while stalling and is re-presented by ID once operands are ready.
- Issue = id_valid & !stall & state==RUN. On issue with id_regwrite & id_rd != 0: cnt[id_rd] <= id_lat+BR_EXTRA.
- All other nonzero cnt decrement by 1 each cycle. Issue overrides decrement on the same register. Hazard checks always use pre-update values, so rd==rs1 checks the old producer.
- id_lat > MAX_LAT is clamped to MAX_LAT.
- FSM:
  - RUN -> FLUSH on redirect & !stall when BR_PENALTY > 1, with fl <= BR_PENALTY-2.
  - In FLUSH, fl decrements; FLUSH -> RUN when fl == 0.
  - BR_PENALTY == 1 never leaves RUN.
- Counters: stall_count +1 per stall cycle; flush_count +1 per cycle with if_id_flush=1. Both saturate at all-ones and never wrap.
- Reset (rst high at an edge): all cnt=0, state=RUN, fl=0, both performance counters 0.
- Outputs while rst is high: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_ctrl_flush=0.
- A reset mid-stall or mid-flush takes effect at the next edge. The scoreboard is fully cleared and no pending hazards survive.

Test Plan:
- Load-use: issue rd=5 with id_lat=1 (cnt=3); next cycle an ALU op reads x5 -> exactly 1 stall cycle (pc_write=0, id_ex_ctrl_flush=1), then it issues; stall_count=1.
- Branch after ALU: ALU op writes x7 (id_lat=0, cnt=2); beq on x7 next cycle -> stall 2 cycles, then resolve; with redirect=1 -> if_id_flush=1 for one cycle; flush_count=1.
- x0 and unused source: write x0 with id_lat=7, then read x0; a producer of x9 followed by an instruction with rs2=9 and id_rs2_used=0 -> no stall in either case.
- WAW: MUL to x3 (id_lat=3, cnt=5), then ALU to x3 (id_lat=0) -> stall until cnt[3] <= 2, i.e. 3 cycles; final cnt[3]=2.
- Multi-cycle flush with BR_PENALTY=3: jal redirect -> if_id_flush high 3 consecutive cycles; id_valid/redirect ignored in cycles 2-3; pc_write=1 throughout.
- Reset mid-stall: load to x4 (cnt=3), consumer stalling, rst pulsed one cycle -> next cycle consumer issues with no stall; stall_count=0; saturation check with PCW=4 holds stall_count at 15.
